pipe_stage_chain: RTL
=====================

Name: pipe_stage_chain

Overview:
- Parametrised, elastic successor to the fixed FD/DE/EM/MW latches.
- A chain of DEPTH registered stages, each WIDTH bits wide plus a valid bit.
- Full-throughput valid/ready backpressure, a global stall, a global flush, and an occupancy count.
- Sits between any two datapath stages; callers pack their stage struct into in_data and unpack it from out_data.

Parameters:
- WIDTH, 32: payload bits per stage (must be ≥1).
- DEPTH, 1: number of register stages (must be ≥1).
- CNTW, $clog2(DEPTH+1): width of the occupancy count (derived; do not override).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, synchronous, active-low.
- stall  in  1  freeze the entire chain this cycle.
- flush  in  1  invalidate all stages; takes priority over everything.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  chain accepts in_data this cycle (combinational).
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  last stage holds valid data.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  payload from the last stage (registered).
- stage_valid  out  DEPTH  valid bit of each stage; bit 0 is the input-side stage.
- count  out  CNTW  number of valid stages.

Behaviour:
- Reset: when nRST=0 at a rising edge, all stage valids, all stage data, out_data and count go to 0. in_ready and out_valid evaluate to 0 while nRST=0. Reset overrides flush and stall, including mid-transfer.
- Advance rule for stage i: adv_i = valid_i & ready_{i+1}. The last stage uses out_ready in place of ready_{i+1}.
- Ready rule for stage i: ready_i = ~valid_i | adv_i. This allows a bubble to collapse in one cycle.
- Ready chain: combinational from out_ready to in_ready, with no registered skid.
- in_ready = ready_0 & ~stall & ~flush.
- out_valid = valid_{DEPTH-1} & ~stall & ~flush.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- On each edge with no stall and no flush:
  - Stage i+1 loads stage i (data and valid=1) when adv_i.
  - Otherwise, stage i+1 clears its valid when it advanced out and was not refilled.
  - Stage 0 loads in_data on in_fire.
  - A stage that is neither loaded nor drained holds its data and valid.
- Stall (flush=0): no state changes; in_ready=0; out_valid=0; count holds.
- Flush: all valids clear on the next edge. in_data offered that cycle is dropped. Stage data registers hold their old contents (don't-care for the bench). count becomes 0. Flush and stall together: flush wins.
- Latency: with out_ready=1 continuously, in_data accepted at edge k appears on out_data with out_valid=1 after edge k+DEPTH-1. Throughput is 1 item/cycle.
- Full (count=DEPTH) with out_ready=0: in_ready=0 and the chain holds. Full with out_ready=1: in_ready=1 and pass-through at full rate.
- Empty: out_valid=0. out_data holds its last value.
- count(next) = count + in_fire − out_fire; never exceeds DEPTH and never underflows.
- Ordering: items leave strictly in acceptance order; no item is duplicated or lost except by flush.
- DEPTH=1 degenerates to a single elastic register: in_ready = ~valid_0 | out_ready.

Test Plan:
- Reset: drive nRST=0 for 2 cycles with in_valid=1 and in_data=0xDEADBEEF (DEPTH=3) → stage_valid=000, count=0, out_valid=0, out_data=0, in_ready=0.
- Streaming: DEPTH=3, out_ready=1, feed 0x1..0x8 back-to-back → out_data sequence is 0x1..0x8 with exactly 2 cycles between first accept and first out_valid; in_ready stays 1 throughout.
- Backpressure: DEPTH=3, out_ready=0, feed 0xA,0xB,0xC,0xD → 0xD is refused (in_ready=0 once count=3), stage_valid=111. Then set out_ready=1 → 0xA,0xB,0xC,0xD exit in order.
- Bubble collapse: DEPTH=4 with stage_valid=1010 and out_ready=0 → in_ready=1; the next accepted word fills stage 0 with no loss; count goes 2→3.
- Stall: mid-stream with count=2, assert stall for 3 cycles while in_valid=1 → in_ready=0, out_valid=0, stage_valid and count unchanged; after release, the stream resumes in order.
- Flush: count=3 with in_valid=1 and in_data=0x55, assert flush together with stall → next cycle stage_valid=000, count=0, and 0x55 never appears on out_data.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register chain with a configurable number of stages.
// Each stage holds a WIDTH-bit payload and a valid bit. The chain supports
// valid/ready backpressure at full throughput, a global stall and a global
// flush, and reports how many stages are occupied. Callers pack their
// stage struct into in_data and unpack it again from out_data.
//
// Ready propagates combinationally from out_ready back to in_ready, so a
// bubble anywhere in the chain is absorbed in the same cycle. There is no
// skid buffer.

module pipe_stage_chain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1,
    // Derived from DEPTH; leave at its default.
    parameter int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNTW-1:0]  count
);

    // Per-stage state.
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CNTW-1:0]  count_q, count_d;

    // ready_ext[i] is the ready of stage i. The extra top bit stands in for
    // the downstream consumer, so the last stage needs no special case.
    logic [DEPTH:0]   ready_ext;
    logic [DEPTH-1:0] adv;

    logic in_fire;
    logic out_fire;

    // Ready/advance chain, evaluated from the output side back to the input.
    always_comb begin
        ready_ext        = '0;
        adv              = '0;
        ready_ext[DEPTH] = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            adv[i]       = valid_q[i] & ready_ext[i+1];
            ready_ext[i] = ~valid_q[i] | adv[i];
        end
    end

    // Handshake outputs, forced low during stall, flush and reset.
    always_comb begin
        in_ready  = ready_ext[0] & ~stall & ~flush & nRST;
        out_valid = valid_q[DEPTH-1] & ~stall & ~flush & nRST;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
    end

    // Next-state for stage valids and payloads.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            // Payload registers keep stale data; only the valids matter.
            valid_d = '0;
        end else if (!stall) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (adv[i-1]) begin
                    valid_d[i] = 1'b1;
                    data_d[i]  = data_q[i-1];
                end else if (adv[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
            if (in_fire) begin
                valid_d[0] = 1'b1;
                data_d[0]  = in_data;
            end else if (adv[0]) begin
                valid_d[0] = 1'b0;
            end
        end
    end

    // Occupancy: one in, one out per cycle at most; flush empties the chain.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (!stall) begin
            count_d = count_q + CNTW'(in_fire) - CNTW'(out_fire);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_data    = data_q[DEPTH-1];
    assign stage_valid = valid_q;
    assign count       = count_q;

    // The occupancy register must always agree with the stage valids.
    a_count_matches_valids: assert property (
        @(posedge CLK) disable iff (!nRST) int'(count_q) == $countones(valid_q)
    );

    a_count_bounded: assert property (
        @(posedge CLK) disable iff (!nRST) int'(count_q) <= int'(DEPTH)
    );

endmodule
